alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, for example the instruction datapath (port 0) and an address/auxiliary unit (port 1). It registers the granted requester's operands and operation code onto the ALU inputs, captures the ALU result and zero flag one cycle later, and returns them with a one-cycle acknowledge. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// The granted port's operands and opcode are registered onto the ALU inputs.
// The result and zero flag are captured one cycle later and returned with a
// one-cycle ACK.
// Optional build macro ALU_ARB_RR_EN selects round-robin arbitration on a tie.
// Without it, port 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; grant and ALU input load happen here
// EXEC  | ALU inputs stable; result and zero flag captured at the end
// DONE  | ACK of the granted port is high; requests are ignored
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    input  logic [OPRN_WIDTH-1:0] OPRN_0,
    input  logic [OPRN_WIDTH-1:0] OPRN_1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RES0,
    output logic [DATA_WIDTH-1:0] RES1,
    output logic                  ZERO0,
    output logic                  ZERO1,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   gnt;
    logic   win;
    logic   any_req;

    assign any_req = REQ0 | REQ1;

`ifdef ALU_ARB_RR_EN
    logic last;

    // Round-robin winner: on a tie the port that was not granted last wins.
    always_comb begin
        win = 1'b0;
        if (REQ0 && REQ1) begin
            win = ~last;
        end else begin
            win = REQ1;
        end
    end

    // Remember the most recently granted port; reset value makes port 0 win the first tie.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= win;
        end
    end
`else
    // Fixed priority winner: port 1 only wins when port 0 is not requesting.
    always_comb begin
        win = ~REQ0;
    end
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass through EXEC and DONE per granted request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        BUSY = (state != IDLE);
    end

    // Grant/load in IDLE, capture and acknowledge in EXEC, clear ACK in DONE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt      <= 1'b0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            RES0     <= '0;
            RES1     <= '0;
            ZERO0    <= 1'b0;
            ZERO1    <= 1'b0;
            ALU_OP1  <= '0;
            ALU_OP2  <= '0;
            ALU_OPRN <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= win;
                        ALU_OP1  <= win ? OP1_1  : OP1_0;
                        ALU_OP2  <= win ? OP2_1  : OP2_0;
                        ALU_OPRN <= win ? OPRN_1 : OPRN_0;
                    end
                end
                EXEC: begin
                    if (gnt) begin
                        RES1  <= ALU_OUT;
                        ZERO1 <= ALU_ZERO;
                        ACK1  <= 1'b1;
                    end else begin
                        RES0  <= ALU_OUT;
                        ZERO0 <= ALU_ZERO;
                        ACK0  <= 1'b1;
                    end
                end
                DONE: begin
                    ACK0 <= 1'b0;
                    ACK1 <= 1'b0;
                end
                default: begin
                    ACK0 <= 1'b0;
                    ACK1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small combinational ALU model.
// Tie expectations follow the ALU_ARB_RR_EN build macro.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0 = 1'b0, REQ1 = 1'b0;
    logic [DW-1:0] OP1_0 = '0, OP2_0 = '0, OP1_1 = '0, OP2_1 = '0;
    logic [OW-1:0] OPRN_0 = '0, OPRN_1 = '0;
    logic          ACK0, ACK1, ZERO0, ZERO1, BUSY, ALU_ZERO;
    logic [DW-1:0] RES0, RES1, ALU_OP1, ALU_OP2, ALU_OUT;
    logic [OW-1:0] ALU_OPRN;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1),
        .OP1_0(OP1_0), .OP2_0(OP2_0), .OP1_1(OP1_1), .OP2_1(OP2_1),
        .OPRN_0(OPRN_0), .OPRN_1(OPRN_1),
        .ACK0(ACK0), .ACK1(ACK1),
        .RES0(RES0), .RES1(RES1),
        .ZERO0(ZERO0), .ZERO1(ZERO1),
        .BUSY(BUSY),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
        .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
    );

    always #5 CLK = ~CLK;

    // ALU model: 1 add, 2 sub, 3 mul, 6 and, 7 or.
    always_comb begin
        case (ALU_OPRN)
            6'h01:   ALU_OUT = ALU_OP1 + ALU_OP2;
            6'h02:   ALU_OUT = ALU_OP1 - ALU_OP2;
            6'h03:   ALU_OUT = ALU_OP1 * ALU_OP2;
            6'h06:   ALU_OUT = ALU_OP1 & ALU_OP2;
            6'h07:   ALU_OUT = ALU_OP1 | ALU_OP2;
            default: ALU_OUT = '0;
        endcase
        ALU_ZERO = (ALU_OUT == '0);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int n;
        RST = 1'b0;
        tick();
        tick();
        checks++;
        if ({ACK0, ACK1, BUSY, ZERO0, ZERO1} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {ACK0, ACK1, BUSY, ZERO0, ZERO1});
        end
        checks++;
        if (RES0 !== '0 || RES1 !== '0) begin
            failures++;
            $display("FAIL reset_res got=%h/%h want=0/0", RES0, RES1);
        end
        checks++;
        if (ALU_OP1 !== '0 || ALU_OP2 !== '0 || ALU_OPRN !== '0) begin
            failures++;
            $display("FAIL reset_alu_in got=%h/%h/%h want=0", ALU_OP1, ALU_OP2, ALU_OPRN);
        end
        RST = 1'b1;
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b want=0", BUSY);
        end

        // Mid-transaction reset: 7*6 loses its ACK, then a reissue gives 42.
        REQ0 = 1'b1; OPRN_0 = 6'h03; OP1_0 = 7; OP2_0 = 6;
        tick();
        checks++;
        if (BUSY !== 1'b1 || ALU_OPRN !== 6'h03) begin
            failures++;
            $display("FAIL exec_entry busy=%b oprn=%h want=1/03", BUSY, ALU_OPRN);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({ACK0, BUSY, ZERO0} !== 3'b0 || RES0 !== '0 || ALU_OP1 !== '0 || ALU_OP2 !== '0 || ALU_OPRN !== '0) begin
            failures++;
            $display("FAIL midreset_clear ack=%b busy=%b res=%h op=%h/%h/%h want=0", ACK0, BUSY, RES0, ALU_OP1, ALU_OP2, ALU_OPRN);
        end
        REQ0 = 1'b0;
        tick();
        tick();
        checks++;
        if (ACK0 !== 1'b0 || RES0 !== '0) begin
            failures++;
            $display("FAIL midreset_noack ack=%b res=%h want=0/0", ACK0, RES0);
        end
        RST = 1'b1;
        tick();
        REQ0 = 1'b1;
        n = 0;
        while (ACK0 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2 || RES0 !== 32'd42) begin
            failures++;
            $display("FAIL reissue latency=%0d res=%0d want=2/42", n, RES0);
        end
        REQ0 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        REQ0 = 1'b1; OPRN_0 = 6'h01; OP1_0 = 5; OP2_0 = 3;
        tick();
        checks++;
        if (ACK0 !== 1'b0 || BUSY !== 1'b1 || ALU_OP1 !== 32'd5 || ALU_OP2 !== 32'd3) begin
            failures++;
            $display("FAIL single_grant ack=%b busy=%b op=%0d/%0d want=0/1/5/3", ACK0, BUSY, ALU_OP1, ALU_OP2);
        end
        tick();
        checks++;
        if (ACK0 !== 1'b1 || ACK1 !== 1'b0 || RES0 !== 32'd8 || ZERO0 !== 1'b0 || RES1 !== '0) begin
            failures++;
            $display("FAIL single_ack ack=%b%b res0=%0d z0=%b res1=%0d want=10/8/0/0", ACK0, ACK1, RES0, ZERO0, RES1);
        end
        REQ0 = 1'b0;
        tick();
        checks++;
        if (ACK0 !== 1'b0 || BUSY !== 1'b0 || RES0 !== 32'd8) begin
            failures++;
            $display("FAIL single_done ack=%b busy=%b res0=%0d want=0/0/8", ACK0, BUSY, RES0);
        end
    endtask

    task automatic test_zero_flag();
        int busy_cnt = 0;
        int ack_cnt = 0;
        REQ1 = 1'b1; OPRN_1 = 6'h02; OP1_1 = 32'h1234; OP2_1 = 32'h1234;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (BUSY === 1'b1) busy_cnt++;
            if (ACK1 === 1'b1) begin
                ack_cnt++;
                REQ1 = 1'b0;
            end
        end
        checks++;
        if (busy_cnt != 2 || ack_cnt != 1) begin
            failures++;
            $display("FAIL zero_busy busy_cycles=%0d acks=%0d want=2/1", busy_cnt, ack_cnt);
        end
        checks++;
        if (RES1 !== '0 || ZERO1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_res res1=%h z1=%b want=0/1", RES1, ZERO1);
        end
        checks++;
        if (RES0 !== 32'd8 || ZERO0 !== 1'b0) begin
            failures++;
            $display("FAIL zero_other res0=%0d z0=%b want=8/0", RES0, ZERO0);
        end
    endtask

    task automatic test_operand_change();
        REQ0 = 1'b1; OPRN_0 = 6'h01; OP1_0 = 9; OP2_0 = 1;
        tick();
        OP1_0 = 1;
        tick();
        checks++;
        if (ACK0 !== 1'b1 || RES0 !== 32'd10 || ALU_OP1 !== 32'd9) begin
            failures++;
            $display("FAIL opchange ack=%b res0=%0d aluop1=%0d want=1/10/9", ACK0, RES0, ALU_OP1);
        end
        REQ0 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int ack_port[4];
        int ack_cyc[4];
        int exp_port[4];
        int na = 0;
        int both = 0;
`ifdef ALU_ARB_RR_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 1};
`endif
        pulse_reset();
        OPRN_0 = 6'h06; OP1_0 = 32'hF0; OP2_0 = 32'h3C;
        OPRN_1 = 6'h07; OP1_1 = 32'hF0; OP2_1 = 32'h0F;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int c = 1; c <= 30 && na < 4; c++) begin
            tick();
            if (ACK0 === 1'b1 && ACK1 === 1'b1) both++;
            if (ACK0 === 1'b1 || ACK1 === 1'b1) begin
                ack_port[na] = (ACK1 === 1'b1) ? 1 : 0;
                ack_cyc[na] = c;
                na++;
`ifndef ALU_ARB_RR_EN
                if (na == 3) REQ0 = 1'b0;
`endif
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        checks++;
        if (na != 4 || both != 0) begin
            failures++;
            $display("FAIL tie_acks count=%0d overlap=%0d want=4/0", na, both);
        end
        for (int i = 0; i < na; i++) begin
            checks++;
            if (ack_port[i] != exp_port[i]) begin
                failures++;
                $display("FAIL tie_order[%0d] got=%0d want=%0d", i, ack_port[i], exp_port[i]);
            end
            checks++;
            if (ack_cyc[i] != 2 + 3 * i) begin
                failures++;
                $display("FAIL tie_timing[%0d] got=%0d want=%0d", i, ack_cyc[i], 2 + 3 * i);
            end
        end
        checks++;
        if (RES0 !== 32'h30 || RES1 !== 32'hFF) begin
            failures++;
            $display("FAIL tie_res res0=%h res1=%h want=30/ff", RES0, RES1);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_flag();
        test_operand_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
